// File: rtl/i2s_tx_serializer.sv
// I2S / left-justified DAC transmitter: stereo pair FIFO feeding a slot serialiser
// driven by codec BCLK/LRCLK that are synchronised into the system clock domain.
module i2s_tx_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int I2S_MODE   = 1
) (
   input  logic                               i_clock,
   input  logic                               i_reset,
   input  logic                               i_codec_bit_clock,
   input  logic                               i_codec_lr_clock,
   output logic                               o_codec_dac_data,
   input  logic [DATA_WIDTH-1:0]              i_data_left,
   input  logic [DATA_WIDTH-1:0]              i_data_right,
   input  logic                               i_data_valid,
   output logic                               o_data_ready,
   output logic                               o_underflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level
);

   localparam int CW = $clog2(SLOT_WIDTH+1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam logic [CW-1:0] SLOT_END = CW'(SLOT_WIDTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

   state_t r_state, w_state_nxt;

   logic r_bclk_meta, r_bclk_stable, r_bclk_delay, r_bclk_fall;
   logic r_lr_meta, r_lr_stable, r_lr_delay, r_lr_fall, r_lr_rise;

   logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]           r_level;
   logic                    w_empty, w_full, w_push, w_pop;
   logic [2*DATA_WIDTH-1:0] w_head;

   logic [DATA_WIDTH-1:0]   r_shift, r_right_hold, w_new_sample;
   logic [CW-1:0]           r_cnt;
   logic                    r_dout, w_slot_start;

   // Three-flop synchronisers; edge flags are registered from stable/delay.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bclk_meta <= 1'b0; r_bclk_stable <= 1'b0; r_bclk_delay <= 1'b0; r_bclk_fall <= 1'b0;
         r_lr_meta   <= 1'b0; r_lr_stable   <= 1'b0; r_lr_delay   <= 1'b0;
         r_lr_fall   <= 1'b0; r_lr_rise     <= 1'b0;
      end else begin
         r_bclk_meta   <= i_codec_bit_clock;
         r_bclk_stable <= r_bclk_meta;
         r_bclk_delay  <= r_bclk_stable;
         r_bclk_fall   <= !r_bclk_stable & r_bclk_delay;
         r_lr_meta     <= i_codec_lr_clock;
         r_lr_stable   <= r_lr_meta;
         r_lr_delay    <= r_lr_stable;
         r_lr_fall     <= !r_lr_stable & r_lr_delay;
         r_lr_rise     <= r_lr_stable & !r_lr_delay;
      end
   end

   assign w_empty      = (r_level == '0);
   assign w_full       = (r_level == FULL_LVL);
   assign o_data_ready = !w_full & !i_reset;
   assign w_push       = i_data_valid & o_data_ready;
   assign w_pop        = r_lr_fall & !w_empty;
   assign w_head       = r_mem[r_rd_ptr];
   assign o_underflow  = r_lr_fall & w_empty & !i_reset;
   assign o_fifo_level = r_level;
   assign o_codec_dac_data = r_dout;

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_data_left, i_data_right};
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // A right-slot start is only honoured once a left slot has begun.
   always_comb begin
      w_state_nxt  = r_state;
      w_slot_start = 1'b0;
      w_new_sample = '0;
      if (r_lr_fall) begin
         w_state_nxt  = S_LEFT;
         w_slot_start = 1'b1;
         w_new_sample = w_pop ? w_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      end else if (r_lr_rise && (r_state != S_IDLE)) begin
         w_state_nxt  = S_RIGHT;
         w_slot_start = 1'b1;
         w_new_sample = r_right_hold;
      end
   end

   // Slot register shifts MSB-first; cnt tracks slot position so surplus BCLKs emit zeros.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_dout       <= 1'b0;
         r_shift      <= '0;
         r_right_hold <= '0;
         r_cnt        <= '0;
      end else if (w_slot_start) begin
         if (r_lr_fall) r_right_hold <= w_pop ? w_head[DATA_WIDTH-1:0] : '0;
         if (I2S_MODE == 0) begin
            r_dout  <= w_new_sample[DATA_WIDTH-1];
            r_shift <= {w_new_sample[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= CW'(1);
         end else begin
            r_dout  <= 1'b0;
            r_shift <= w_new_sample;
            r_cnt   <= '0;
         end
      end else if (r_bclk_fall && (r_state != S_IDLE)) begin
         if (r_cnt < SLOT_END) begin
            r_dout  <= r_shift[DATA_WIDTH-1];
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
         end else begin
            r_dout  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench: three instances (I2S 24/32, left-justified 24/32, I2S 16/17)
// share the system clock, reset and codec clocks generated here.
module tb_i2s_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, bclk, lrclk;

   logic [23:0] d0_l, d0_r, d1_l, d1_r;
   logic [15:0] d2_l, d2_r;
   logic        d0_v, d1_v, d2_v;
   logic        d0_dout, d1_dout, d2_dout;
   logic        d0_rdy, d1_rdy, d2_rdy;
   logic        d0_uf, d1_uf, d2_uf;
   logic [2:0]  d0_lvl, d1_lvl, d2_lvl;

   int errors = 0;
   int checks = 0;
   int uf0 = 0;
   logic [31:0] cap_l [3];
   logic [31:0] cap_r [3];

   i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .I2S_MODE(1)) u0 (
      .i_clock(clk), .i_reset(rst), .i_codec_bit_clock(bclk), .i_codec_lr_clock(lrclk),
      .o_codec_dac_data(d0_dout), .i_data_left(d0_l), .i_data_right(d0_r),
      .i_data_valid(d0_v), .o_data_ready(d0_rdy), .o_underflow(d0_uf), .o_fifo_level(d0_lvl));

   i2s_tx_serializer #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .I2S_MODE(0)) u1 (
      .i_clock(clk), .i_reset(rst), .i_codec_bit_clock(bclk), .i_codec_lr_clock(lrclk),
      .o_codec_dac_data(d1_dout), .i_data_left(d1_l), .i_data_right(d1_r),
      .i_data_valid(d1_v), .o_data_ready(d1_rdy), .o_underflow(d1_uf), .o_fifo_level(d1_lvl));

   i2s_tx_serializer #(.DATA_WIDTH(16), .SLOT_WIDTH(17), .FIFO_DEPTH(4), .I2S_MODE(1)) u2 (
      .i_clock(clk), .i_reset(rst), .i_codec_bit_clock(bclk), .i_codec_lr_clock(lrclk),
      .o_codec_dac_data(d2_dout), .i_data_left(d2_l), .i_data_right(d2_r),
      .i_data_valid(d2_v), .o_data_ready(d2_rdy), .o_underflow(d2_uf), .o_fifo_level(d2_lvl));

   always @(negedge clk) if (d0_uf) uf0++;

   // One LRCLK frame, BCLK = clk/16; LRCLK changes with the BCLK fall, data sampled at BCLK rise.
   task automatic codec_frame(input int slot);
      for (int h = 0; h < 2; h++) begin
         for (int i = 0; i < slot; i++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (i == 0) lrclk = (h == 1);
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            if (h == 0) begin
               cap_l[0] = {cap_l[0][30:0], d0_dout};
               cap_l[1] = {cap_l[1][30:0], d1_dout};
               cap_l[2] = {cap_l[2][30:0], d2_dout};
            end else begin
               cap_r[0] = {cap_r[0][30:0], d0_dout};
               cap_r[1] = {cap_r[1][30:0], d1_dout};
               cap_r[2] = {cap_r[2][30:0], d2_dout};
            end
            repeat (7) @(negedge clk);
         end
      end
   endtask

   task automatic push0(input logic [23:0] l, input logic [23:0] r);
      @(negedge clk);
      checks++;
      if (d0_rdy !== 1'b1) begin errors++; $display("FAIL push0_ready got=%b exp=1", d0_rdy); end
      d0_l = l; d0_r = r; d0_v = 1'b1;
      @(negedge clk);
      d0_v = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bclk = 1'b1; lrclk = 1'b1;
      d0_v = 0; d1_v = 0; d2_v = 0;
      d0_l = 0; d0_r = 0; d1_l = 0; d1_r = 0; d2_l = 0; d2_r = 0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (d0_dout !== 1'b0) begin errors++; $display("FAIL rst_dout got=%b exp=0", d0_dout); end
      if (d0_lvl !== 3'd0)  begin errors++; $display("FAIL rst_level got=%0d exp=0", d0_lvl); end
      if (d0_rdy !== 1'b0)  begin errors++; $display("FAIL rst_ready got=%b exp=0", d0_rdy); end
      if (d0_uf !== 1'b0)   begin errors++; $display("FAIL rst_underflow got=%b exp=0", d0_uf); end
      rst = 1'b0;
      @(negedge clk);
      checks += 2;
      if (d0_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", d0_rdy); end
      if (d0_lvl !== 3'd0) begin errors++; $display("FAIL post_rst_level got=%0d exp=0", d0_lvl); end
      repeat (10) @(negedge clk);
      checks += 2;
      if (d0_dout !== 1'b0) begin errors++; $display("FAIL idle_dout got=%b exp=0", d0_dout); end
      if (uf0 != 0)         begin errors++; $display("FAIL idle_underflow got=%0d exp=0", uf0); end
   endtask

   task automatic test_i2s_frame();
      int ub;
      push0(24'hA5A5A5, 24'h3C3C3C);
      ub = uf0;
      codec_frame(32);
      checks += 3;
      if (cap_l[0] !== {1'b0, 24'hA5A5A5, 7'b0})
         begin errors++; $display("FAIL i2s_left got=%h exp=%h", cap_l[0], {1'b0, 24'hA5A5A5, 7'b0}); end
      if (cap_r[0] !== {1'b0, 24'h3C3C3C, 7'b0})
         begin errors++; $display("FAIL i2s_right got=%h exp=%h", cap_r[0], {1'b0, 24'h3C3C3C, 7'b0}); end
      if (uf0 != ub) begin errors++; $display("FAIL i2s_underflow got=%0d exp=0", uf0 - ub); end
   endtask

   task automatic test_left_justified();
      @(negedge clk);
      d1_l = 24'h800001; d1_r = 24'h7FFFFE; d1_v = 1'b1;
      @(negedge clk);
      d1_v = 1'b0;
      codec_frame(32);
      checks += 2;
      if (cap_l[1] !== {24'h800001, 8'h00})
         begin errors++; $display("FAIL lj_left got=%h exp=%h", cap_l[1], {24'h800001, 8'h00}); end
      if (cap_r[1] !== {24'h7FFFFE, 8'h00})
         begin errors++; $display("FAIL lj_right got=%h exp=%h", cap_r[1], {24'h7FFFFE, 8'h00}); end
   endtask

   task automatic test_min_slot();
      @(negedge clk);
      d2_l = 16'hFFFF; d2_r = 16'h8001; d2_v = 1'b1;
      @(negedge clk);
      d2_v = 1'b0;
      codec_frame(17);
      checks += 2;
      if (cap_l[2][16:0] !== {1'b0, 16'hFFFF})
         begin errors++; $display("FAIL min_left got=%h exp=%h", cap_l[2][16:0], {1'b0, 16'hFFFF}); end
      if (cap_r[2][16:0] !== {1'b0, 16'h8001})
         begin errors++; $display("FAIL min_right got=%h exp=%h", cap_r[2][16:0], {1'b0, 16'h8001}); end
   endtask

   task automatic test_underflow();
      int ub;
      ub = uf0;
      fork
         codec_frame(32);
         begin
            repeat (600) @(negedge clk);
            push0(24'h123456, 24'h654321);
         end
      join
      checks += 4;
      if (cap_l[0] !== 32'h0) begin errors++; $display("FAIL uf_left got=%h exp=0", cap_l[0]); end
      if (cap_r[0] !== 32'h0) begin errors++; $display("FAIL uf_right got=%h exp=0", cap_r[0]); end
      if (uf0 - ub != 1) begin errors++; $display("FAIL uf_pulse_cycles got=%0d exp=1", uf0 - ub); end
      if (d0_lvl !== 3'd1) begin errors++; $display("FAIL uf_level got=%0d exp=1", d0_lvl); end
      ub = uf0;
      codec_frame(32);
      checks += 3;
      if (cap_l[0] !== {1'b0, 24'h123456, 7'b0})
         begin errors++; $display("FAIL uf_next_left got=%h exp=%h", cap_l[0], {1'b0, 24'h123456, 7'b0}); end
      if (cap_r[0] !== {1'b0, 24'h654321, 7'b0})
         begin errors++; $display("FAIL uf_next_right got=%h exp=%h", cap_r[0], {1'b0, 24'h654321, 7'b0}); end
      if (uf0 != ub) begin errors++; $display("FAIL uf_next_pulse got=%0d exp=0", uf0 - ub); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] pl [4];
      logic [23:0] pr [4];
      int k;
      pl = '{24'hC00003, 24'h5A0F00, 24'h000001, 24'hFFFFFF};
      pr = '{24'h0F0F0F, 24'h800000, 24'h7E7E7E, 24'h13579B};
      k = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (k < 4) begin d0_l = pl[k]; d0_r = pr[k]; end
         d0_v = 1'b1;
         if (d0_rdy) k++;
      end
      @(negedge clk);
      checks += 3;
      if (k != 4)          begin errors++; $display("FAIL bp_pushes got=%0d exp=4", k); end
      if (d0_lvl !== 3'd4) begin errors++; $display("FAIL bp_level got=%0d exp=4", d0_lvl); end
      if (d0_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", d0_rdy); end
      d0_v = 1'b0;
      for (int f = 0; f < 4; f++) begin
         if (f == 0) begin
            fork
               codec_frame(32);
               begin
                  int n;
                  n = 0;
                  while (d0_lvl === 3'd4 && n < 2000) begin
                     checks++;
                     if (d0_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_early got=%b exp=0", d0_rdy); end
                     @(negedge clk);
                     n++;
                  end
                  checks += 2;
                  if (d0_lvl !== 3'd3) begin errors++; $display("FAIL bp_pop_level got=%0d exp=3", d0_lvl); end
                  if (d0_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got=%b exp=1", d0_rdy); end
               end
            join
         end else begin
            codec_frame(32);
         end
         checks += 2;
         if (cap_l[0] !== {1'b0, pl[f], 7'b0})
            begin errors++; $display("FAIL bp_left%0d got=%h exp=%h", f, cap_l[0], {1'b0, pl[f], 7'b0}); end
         if (cap_r[0] !== {1'b0, pr[f], 7'b0})
            begin errors++; $display("FAIL bp_right%0d got=%h exp=%h", f, cap_r[0], {1'b0, pr[f], 7'b0}); end
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 4; i++) push0(24'h900000 + 24'(i), 24'h0A0000 + 24'(i));
      fork
         codec_frame(32);
         begin
            repeat (169) @(negedge clk);
            checks++;
            if (d0_lvl !== 3'd3) begin errors++; $display("FAIL mid_level_before got=%0d exp=3", d0_lvl); end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks += 2;
            if (d0_dout !== 1'b0) begin errors++; $display("FAIL mid_rst_dout got=%b exp=0", d0_dout); end
            if (d0_lvl !== 3'd0)  begin errors++; $display("FAIL mid_rst_level got=%0d exp=0", d0_lvl); end
         end
      join
      checks += 2;
      if (cap_r[0] !== 32'h0) begin errors++; $display("FAIL mid_right_silent got=%h exp=0", cap_r[0]); end
      if (cap_l[0][20:0] !== 21'h0) begin errors++; $display("FAIL mid_left_tail got=%h exp=0", cap_l[0][20:0]); end
      push0(24'h2468AC, 24'hFEDCBA);
      codec_frame(32);
      checks += 2;
      if (cap_l[0] !== {1'b0, 24'h2468AC, 7'b0})
         begin errors++; $display("FAIL mid_restart_left got=%h exp=%h", cap_l[0], {1'b0, 24'h2468AC, 7'b0}); end
      if (cap_r[0] !== {1'b0, 24'hFEDCBA, 7'b0})
         begin errors++; $display("FAIL mid_restart_right got=%h exp=%h", cap_r[0], {1'b0, 24'hFEDCBA, 7'b0}); end
   endtask

   initial begin
      test_reset();
      test_i2s_frame();
      test_left_justified();
      test_min_slot();
      test_underflow();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
